// File: rtl/sine_rom_arbiter_if.sv
// Requester, grant/response and ROM-port bundle for sine_rom_arbiter.
// master = requesters plus ROM model, slave = the arbiter.
interface sine_rom_arbiter_if #(
  parameter int NUM_REQ       = 4,
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 8
);
  logic [NUM_REQ-1:0]               req;
  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0]               gnt;
  logic [NUM_REQ-1:0]               rsp_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0]    rsp_data;
  logic [ADDRESS_WIDTH-1:0]         rom_addr;
  logic [ADDRESS_WIDTH-1:0]         rom_addr2;
  logic [DATA_WIDTH-1:0]            rom_dout;
  logic [DATA_WIDTH-1:0]            rom_dout2;

  modport master (
    output req, req_addr, rom_dout, rom_dout2,
    input  gnt, rsp_valid, rsp_data,
    input  rom_addr, rom_addr2
  );

  modport slave (
    input  req, req_addr, rom_dout, rom_dout2,
    output gnt, rsp_valid, rsp_data,
    output rom_addr, rom_addr2
  );
endinterface

// File: rtl/sine_rom_arbiter.sv
// Round-robin sharing of the two sine ROM read ports, two grants/cycle.
// Define SINE_ROM_ARB_FIXED_PRIO_EN to pin requester 0 onto port A.
module sine_rom_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 8
) (
  input logic               clk,
  input logic               rst_n,
  sine_rom_arbiter_if.slave bus
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
`ifdef SINE_ROM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  typedef logic [IW-1:0] idx_t;

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("sine_rom_arbiter: NUM_REQ must be within 2..8");
  end

  function automatic idx_t wrap(input idx_t p, input int unsigned off);
    int unsigned s;
    s = int'(p) + off;
    return idx_t'(s % NUM_REQ);
  endfunction

  idx_t ptr_q, ptr_d;
  idx_t win_a, win_b;
  logic has_a, has_b, pinned;

  idx_t tag_a_q, tag_b_q, tag_a_r, tag_b_r;
  logic vld_a_q, vld_b_q, vld_a_r, vld_b_r;

  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] rv_q, rv_d;
  logic [ADDRESS_WIDTH-1:0] addr_a_q, addr_b_q;
  logic [NUM_REQ*DATA_WIDTH-1:0] rsp_data_d;

  // Walk from ptr; winners are the first two hits in circular order.
  always_comb begin
    has_a  = 1'b0;
    has_b  = 1'b0;
    win_a  = '0;
    win_b  = '0;
    pinned = FIXED && bus.req[0];
    if (pinned) begin
      has_a = 1'b1;
    end
    for (int off = 0; off < NUM_REQ; off++) begin
      if (bus.req[wrap(ptr_q, unsigned'(off))] &&
          !(FIXED && wrap(ptr_q, unsigned'(off)) == '0)) begin
        if (!has_a) begin
          has_a = 1'b1;
          win_a = wrap(ptr_q, unsigned'(off));
        end else if (!has_b) begin
          has_b = 1'b1;
          win_b = wrap(ptr_q, unsigned'(off));
        end
      end
    end
    if (has_b)
      ptr_d = wrap(win_b, 1);
    else if (has_a && !pinned)
      ptr_d = wrap(win_a, 1);
    else
      ptr_d = ptr_q;
  end

  always_comb begin
    gnt_d = '0;
    rv_d  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if ((has_a && win_a == idx_t'(i)) ||
          (has_b && win_b == idx_t'(i)))
        gnt_d[i] = 1'b1;
      if ((vld_a_q && tag_a_q == idx_t'(i)) ||
          (vld_b_q && tag_b_q == idx_t'(i)))
        rv_d[i] = 1'b1;
    end
  end

  // Response stage tags line up with the ROM's registered output.
  always_comb begin
    rsp_data_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (vld_a_r && tag_a_r == idx_t'(i))
        rsp_data_d[i*DATA_WIDTH +: DATA_WIDTH] = bus.rom_dout;
      else if (vld_b_r && tag_b_r == idx_t'(i))
        rsp_data_d[i*DATA_WIDTH +: DATA_WIDTH] = bus.rom_dout2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q    <= '0;
      gnt_q    <= '0;
      rv_q     <= '0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      tag_a_q  <= '0;
      tag_b_q  <= '0;
      tag_a_r  <= '0;
      tag_b_r  <= '0;
      vld_a_q  <= 1'b0;
      vld_b_q  <= 1'b0;
      vld_a_r  <= 1'b0;
      vld_b_r  <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      rv_q    <= rv_d;
      vld_a_q <= has_a;
      vld_b_q <= has_b;
      vld_a_r <= vld_a_q;
      vld_b_r <= vld_b_q;
      tag_a_r <= tag_a_q;
      tag_b_r <= tag_b_q;
      if (has_a) begin
        tag_a_q  <= win_a;
        addr_a_q <= bus.req_addr[int'(win_a)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      end
      if (has_b) begin
        tag_b_q  <= win_b;
        addr_b_q <= bus.req_addr[int'(win_b)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      end
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.rsp_valid = rv_q;
  assign bus.rsp_data  = rsp_data_d;
  assign bus.rom_addr  = addr_a_q;
  assign bus.rom_addr2 = addr_b_q;
endmodule

// File: tb/tb_sine_rom_arbiter.sv
// Directed vector bench for sine_rom_arbiter with a behavioural ROM.
// Covers reset, dual grant, rotation, wrap and single-port streaming.
module tb_sine_rom_arbiter;
  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sine_rom_arbiter_if #(
    .NUM_REQ(N), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)
  ) bus ();

  sine_rom_arbiter #(
    .NUM_REQ(N), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  function automatic logic [7:0] rom_f(input logic [7:0] a);
    return {a[3:0], a[7:4]} ^ 8'hA5;
  endfunction

  always_ff @(posedge clk) begin
    bus.rom_dout  <= rom_f(bus.rom_addr);
    bus.rom_dout2 <= rom_f(bus.rom_addr2);
  end

  typedef struct {
    bit          rst;
    logic [3:0]  req;
    logic [31:0] addr;
    logic [3:0]  gnt;
    logic [7:0]  ra;
    logic [7:0]  ra2;
    logic [3:0]  rv;
    logic [31:0] rd;
  } vec_t;

  vec_t tv[$];
  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    nchk++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic chk_all(input string n, input logic [3:0] g,
                         input logic [7:0] a, input logic [7:0] a2,
                         input logic [3:0] v, input logic [31:0] d);
    chk({n, " gnt"}, 32'(bus.gnt), 32'(g));
    chk({n, " rom_addr"}, 32'(bus.rom_addr), 32'(a));
    chk({n, " rom_addr2"}, 32'(bus.rom_addr2), 32'(a2));
    chk({n, " rsp_valid"}, 32'(bus.rsp_valid), 32'(v));
    chk({n, " rsp_data"}, bus.rsp_data, d);
  endtask

  localparam logic [31:0] AQ = 32'h31211101;

  initial begin
`ifdef SINE_ROM_ARB_FIXED_PRIO_EN
    tv.push_back('{1, 4'b1111, AQ, 4'b0011, 8'h01, 8'h11, 4'b0000, 32'h0});
    tv.push_back('{0, 4'b1111, AQ, 4'b0101, 8'h01, 8'h21, 4'b0011,
                   {8'h0, 8'h0, rom_f(8'h11), rom_f(8'h01)}});
    tv.push_back('{0, 4'b1111, AQ, 4'b1001, 8'h01, 8'h31, 4'b0101,
                   {8'h0, rom_f(8'h21), 8'h0, rom_f(8'h01)}});
    tv.push_back('{0, 4'b1111, AQ, 4'b0011, 8'h01, 8'h11, 4'b1001,
                   {rom_f(8'h31), 8'h0, 8'h0, rom_f(8'h01)}});
    tv.push_back('{0, 4'b0000, AQ, 4'b0000, 8'h01, 8'h11, 4'b0011,
                   {8'h0, 8'h0, rom_f(8'h11), rom_f(8'h01)}});
`else
    // dual grant from reset
    tv.push_back('{1, 4'b0101, 32'h00800010, 4'b0101, 8'h10, 8'h80,
                   4'b0000, 32'h0});
    tv.push_back('{0, 4'b0000, 32'h00800010, 4'b0000, 8'h10, 8'h80,
                   4'b0101, {8'h0, rom_f(8'h80), 8'h0, rom_f(8'h10)}});
    // full contention rotates in pairs
    tv.push_back('{1, 4'b1111, AQ, 4'b0011, 8'h01, 8'h11, 4'b0000, 32'h0});
    tv.push_back('{0, 4'b1111, AQ, 4'b1100, 8'h21, 8'h31, 4'b0011,
                   {8'h0, 8'h0, rom_f(8'h11), rom_f(8'h01)}});
    tv.push_back('{0, 4'b1111, AQ, 4'b0011, 8'h01, 8'h11, 4'b1100,
                   {rom_f(8'h31), rom_f(8'h21), 8'h0, 8'h0}});
    tv.push_back('{0, 4'b1111, AQ, 4'b1100, 8'h21, 8'h31, 4'b0011,
                   {8'h0, 8'h0, rom_f(8'h11), rom_f(8'h01)}});
    tv.push_back('{0, 4'b0000, AQ, 4'b0000, 8'h21, 8'h31, 4'b1100,
                   {rom_f(8'h31), rom_f(8'h21), 8'h0, 8'h0}});
    tv.push_back('{0, 4'b0000, AQ, 4'b0000, 8'h21, 8'h31, 4'b0000, 32'h0});
    // three requesters wrap around the pointer
    tv.push_back('{0, 4'b0111, AQ, 4'b0011, 8'h01, 8'h11, 4'b0000, 32'h0});
    tv.push_back('{0, 4'b0111, AQ, 4'b0101, 8'h21, 8'h01, 4'b0011,
                   {8'h0, 8'h0, rom_f(8'h11), rom_f(8'h01)}});
    tv.push_back('{0, 4'b0111, AQ, 4'b0110, 8'h11, 8'h21, 4'b0101,
                   {8'h0, rom_f(8'h21), 8'h0, rom_f(8'h01)}});
    tv.push_back('{0, 4'b0000, AQ, 4'b0000, 8'h11, 8'h21, 4'b0110,
                   {8'h0, rom_f(8'h21), rom_f(8'h11), 8'h0}});
    // lone requester streams on port A, port B address holds
    tv.push_back('{0, 4'b1000, 32'hFE211101, 4'b1000, 8'hFE, 8'h21,
                   4'b0000, 32'h0});
    tv.push_back('{0, 4'b1000, 32'hFF211101, 4'b1000, 8'hFF, 8'h21,
                   4'b1000, {rom_f(8'hFE), 24'h0}});
    tv.push_back('{0, 4'b1000, 32'h00211101, 4'b1000, 8'h00, 8'h21,
                   4'b1000, {rom_f(8'hFF), 24'h0}});
    tv.push_back('{0, 4'b0000, 32'h00211101, 4'b0000, 8'h00, 8'h21,
                   4'b1000, {rom_f(8'h00), 24'h0}});
    tv.push_back('{0, 4'b0000, 32'h00211101, 4'b0000, 8'h00, 8'h21,
                   4'b0000, 32'h0});
`endif

    bus.req      = '0;
    bus.req_addr = '0;
    rst_n        = 1'b0;
    @(posedge clk);
    #1;
    chk_all("reset", 4'b0000, 8'h00, 8'h00, 4'b0000, 32'h0);

    // reset lands while two grants are in flight
    rst_n        = 1'b1;
    bus.req      = 4'b0101;
    bus.req_addr = 32'h00800010;
    @(posedge clk);
    #1;
    chk("inflight gnt", 32'(bus.gnt), 32'(4'b0101));
    #1;
    rst_n = 1'b0;
    #1;
    chk_all("midrst", 4'b0000, 8'h00, 8'h00, 4'b0000, 32'h0);
    bus.req      = 4'b0001;
    bus.req_addr = 32'h00000040;
    rst_n        = 1'b1;
    @(posedge clk);
    #1;
    chk("post gnt", 32'(bus.gnt), 32'(4'b0001));
    chk("post rom_addr", 32'(bus.rom_addr), 32'h40);
    chk("post rsp_valid0", 32'(bus.rsp_valid), 32'h0);
    bus.req = 4'b0000;
    @(posedge clk);
    #1;
    chk("post rsp_valid", 32'(bus.rsp_valid), 32'(4'b0001));
    chk("post rsp_data", bus.rsp_data, {24'h0, rom_f(8'h40)});

    for (int i = 0; i < tv.size(); i++) begin
      if (tv[i].rst) begin
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
      end
      bus.req      = tv[i].req;
      bus.req_addr = tv[i].addr;
      @(posedge clk);
      #1;
      chk_all($sformatf("v%0d", i), tv[i].gnt, tv[i].ra, tv[i].ra2,
              tv[i].rv, tv[i].rd);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
